// File: rtl/key_conditioner.sv
`default_nettype none
// ============================================================================
// key_conditioner : synchronise, debounce and pulse-encode active-low keys
// Rev 1.0
// ============================================================================
module key_conditioner #(
   parameter int NKEYS           = 2,
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int LONG_CYCLES     = 50000000
) (
   input  logic             CLOCK_50,
   input  logic             RESETN,
   input  logic [NKEYS-1:0] KEY,
   output logic [NKEYS-1:0] KEY_LEVEL,
   output logic [NKEYS-1:0] KEY_PRESS,
   output logic [NKEYS-1:0] KEY_RELEASE,
   output logic [NKEYS-1:0] KEY_LONG
);

   localparam int DW = $clog2(DEBOUNCE_CYCLES);
   localparam int LW = $clog2(LONG_CYCLES + 1);

   localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [DW-1:0] DEB_ONE   = DW'(1);
   localparam logic [LW-1:0] LONG_MAX  = LW'(LONG_CYCLES);
   localparam logic [LW-1:0] LONG_LAST = LW'(LONG_CYCLES - 1);
   localparam logic [LW-1:0] LONG_ONE  = LW'(1);

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PRESS_WAIT   = 2'd1,
      HELD         = 2'd2,
      RELEASE_WAIT = 2'd3
   } state_t;

   generate
      for (genvar i = 0; i < NKEYS; i++) begin : g_key
         logic          sync_a;
         logic          sync_b;
         logic          pressed;
         state_t        state;
         logic [DW-1:0] deb_cnt;
         logic [LW-1:0] long_cnt;
         logic          level_q;
         logic          press_q;
         logic          rel_q;
         logic          long_q;

         // Raw key is active-low; pressed is the synchronised, active-high sample.
         assign pressed = ~sync_b;

         always_ff @(posedge CLOCK_50 or negedge RESETN) begin
            if (!RESETN) begin
               sync_a   <= 1'b1;
               sync_b   <= 1'b1;
               state    <= IDLE;
               deb_cnt  <= '0;
               long_cnt <= '0;
               level_q  <= 1'b0;
               press_q  <= 1'b0;
               rel_q    <= 1'b0;
               long_q   <= 1'b0;
            end else begin
               sync_a  <= KEY[i];
               sync_b  <= sync_a;
               press_q <= 1'b0;
               rel_q   <= 1'b0;
               long_q  <= 1'b0;

               case (state)
                  IDLE: begin
                     if (pressed) begin
                        state   <= PRESS_WAIT;
                        deb_cnt <= DEB_ONE;
                     end
                  end
                  PRESS_WAIT: begin
                     if (!pressed) begin
                        state   <= IDLE;
                        deb_cnt <= '0;
                     end else if (deb_cnt == DEB_LAST) begin
                        state    <= HELD;
                        deb_cnt  <= '0;
                        long_cnt <= '0;
                        press_q  <= 1'b1;
                        level_q  <= 1'b1;
                     end else begin
                        deb_cnt <= deb_cnt + DEB_ONE;
                     end
                  end
                  HELD: begin
                     // Saturating count gives exactly one long pulse per press.
                     if (long_cnt < LONG_MAX) begin
                        long_cnt <= long_cnt + LONG_ONE;
                     end
                     if (long_cnt == LONG_LAST) begin
                        long_q <= 1'b1;
                     end
                     if (!pressed) begin
                        state   <= RELEASE_WAIT;
                        deb_cnt <= DEB_ONE;
                     end
                  end
                  RELEASE_WAIT: begin
                     if (pressed) begin
                        state   <= HELD;
                        deb_cnt <= '0;
                     end else if (deb_cnt == DEB_LAST) begin
                        state   <= IDLE;
                        deb_cnt <= '0;
                        rel_q   <= 1'b1;
                        level_q <= 1'b0;
                     end else begin
                        deb_cnt <= deb_cnt + DEB_ONE;
                     end
                  end
                  default: begin
                     state <= IDLE;
                  end
               endcase
            end
         end

         assign KEY_LEVEL[i]   = level_q;
         assign KEY_PRESS[i]   = press_q;
         assign KEY_RELEASE[i] = rel_q;
         assign KEY_LONG[i]    = long_q;
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_key_conditioner.sv
`default_nettype none
// ============================================================================
// tb_key_conditioner : directed vectors for key_conditioner (D=4, L=10, 2 keys)
// Rev 1.0
// ============================================================================
module tb_key_conditioner;

   localparam int NK  = 2;
   localparam int DEB = 4;
   localparam int LNG = 10;

   logic          clk;
   logic          rst_n;
   logic [NK-1:0] key;
   logic [NK-1:0] lvl;
   logic [NK-1:0] prs;
   logic [NK-1:0] rel;
   logic [NK-1:0] lng;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [1:0] key;
      logic [1:0] lvl;
      logic [1:0] prs;
      logic [1:0] rel;
      logic [1:0] lng;
   } vec_t;

   vec_t tbl[$];

   key_conditioner #(
      .NKEYS          (NK),
      .DEBOUNCE_CYCLES(DEB),
      .LONG_CYCLES    (LNG)
   ) dut (
      .CLOCK_50   (clk),
      .RESETN     (rst_n),
      .KEY        (key),
      .KEY_LEVEL  (lvl),
      .KEY_PRESS  (prs),
      .KEY_RELEASE(rel),
      .KEY_LONG   (lng)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [1:0] el, input logic [1:0] ep,
                        input logic [1:0] er, input logic [1:0] eg);
      checks++;
      if ({lvl, prs, rel, lng} !== {el, ep, er, eg}) begin
         errors++;
         $display("FAIL %s: got level=%b press=%b release=%b long=%b, expected level=%b press=%b release=%b long=%b",
                  name, lvl, prs, rel, lng, el, ep, er, eg);
      end
   endtask

   // Drive keys mid-cycle, let the next rising edge capture them, sample 1 ns later.
   task automatic step(input logic [1:0] k);
      @(negedge clk);
      key = k;
      @(posedge clk);
      #1;
   endtask

   task automatic add(input logic [1:0] k, input logic [1:0] l, input logic [1:0] p,
                      input logic [1:0] r, input logic [1:0] g);
      vec_t v;
      v.key = k; v.lvl = l; v.prs = p; v.rel = r; v.lng = g;
      tbl.push_back(v);
   endtask

   initial begin
      // Clean press on key 0: held low 30 edges, press at E5, long at E15, release at R5 (=E35).
      for (int j = 0; j < 38; j++) begin
         add((j < 30) ? 2'b10 : 2'b11,
             {1'b0, (j >= 5 && j < 35)},
             {1'b0, (j == 5)},
             {1'b0, (j == 35)},
             {1'b0, (j == 15)});
      end
      // Bounce on key 0: 0,0,1,0,0,0,0 then low; press after 4 agreeing samples (k=8),
      // released at k=10 so release at k=15 and no long press.
      for (int k = 0; k < 18; k++) begin
         add((k < 10 && k != 2) ? 2'b10 : 2'b11,
             {1'b0, (k >= 8 && k < 15)},
             {1'b0, (k == 8)},
             {1'b0, (k == 15)},
             2'b00);
      end
      // Short glitch on key 1: low for 3 edges never reaches HELD.
      for (int k = 0; k < 8; k++) begin
         add((k < 3) ? 2'b01 : 2'b11, 2'b00, 2'b00, 2'b00, 2'b00);
      end

      key   = 2'b11;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #2 check("reset_state", 2'b00, 2'b00, 2'b00, 2'b00);
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step(2'b11);
         check($sformatf("idle[%0d]", k), 2'b00, 2'b00, 2'b00, 2'b00);
      end

      for (int n = 0; n < tbl.size(); n++) begin
         step(tbl[n].key);
         check($sformatf("tbl[%0d]", n), tbl[n].lvl, tbl[n].prs, tbl[n].rel, tbl[n].lng);
      end

      // Key 1 bounces high for 3 edges while HELD: no release, long 3 cycles late (18 not 15).
      for (int s = 0; s < 33; s++) begin
         logic k1;
         k1 = !(s < 25 && (s < 8 || s > 10));
         step({k1, 1'b1});
         check($sformatf("held_glitch[%0d]", s),
               {(s >= 5 && s < 30), 1'b0},
               {(s == 5), 1'b0},
               {(s == 30), 1'b0},
               {(s == 18), 1'b0});
      end

      // Independence: key 1 pressed two cycles after key 0; both short taps.
      for (int s = 0; s < 17; s++) begin
         logic k0;
         logic k1;
         k0 = !(s < 9);
         k1 = !(s >= 2 && s < 9);
         step({k1, k0});
         check($sformatf("indep[%0d]", s),
               {(s >= 7 && s < 14), (s >= 5 && s < 14)},
               {(s == 7), (s == 5)},
               {(s == 14), (s == 14)},
               2'b00);
      end

      // Both keys pressed, then asynchronous reset mid-cycle while held.
      for (int s = 0; s < 7; s++) begin
         step(2'b00);
         check($sformatf("prehold[%0d]", s),
               (s >= 5) ? 2'b11 : 2'b00,
               (s == 5) ? 2'b11 : 2'b00,
               2'b00, 2'b00);
      end
      #2 rst_n = 1'b0;
      #1 check("reset_async", 2'b00, 2'b00, 2'b00, 2'b00);
      for (int s = 0; s < 2; s++) begin
         @(posedge clk);
         #1 check($sformatf("in_reset[%0d]", s), 2'b00, 2'b00, 2'b00, 2'b00);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int f = 0; f < 8; f++) begin
         @(posedge clk);
         #1 check($sformatf("post_reset[%0d]", f),
                  (f >= 5) ? 2'b11 : 2'b00,
                  (f == 5) ? 2'b11 : 2'b00,
                  2'b00, 2'b00);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/key_conditioner.md
# key_conditioner

Conditions the raw active-low DE10-Lite pushbuttons into clean per-key signals for the register-file demo top level. Each key is synchronised, debounced and turned into a debounced level plus single-cycle press, release and long-press pulses. The press pulses replace the raw `~KEY[n]` terms that drive the register-file write strobe and the display/LED latch enables downstream, so one button press produces exactly one write or latch.

## Interface
- `NKEYS`, default 2: number of independent keys.
- `DEBOUNCE_CYCLES`, default 1000000 (20 ms at 50 MHz): number of consecutive agreeing synchronised samples needed to accept a change. Must be ≥ 2.
- `LONG_CYCLES`, default 50000000 (1 s): number of cycles spent in HELD before the long-press pulse fires. Must be ≥ 1.
- `CLOCK_50`, in, 1: sole clock, rising edge.
- `RESETN`, in, 1: asynchronous, active-low reset.
- `KEY`, in, NKEYS: raw pushbuttons. 0 means pressed. Asynchronous to `CLOCK_50` and bouncy.
- `KEY_LEVEL`, out, NKEYS: debounced state. 1 means pressed.
- `KEY_PRESS`, out, NKEYS: one-cycle pulse on an accepted press.
- `KEY_RELEASE`, out, NKEYS: one-cycle pulse on an accepted release.
- `KEY_LONG`, out, NKEYS: one-cycle pulse once per press after the key has been held for `LONG_CYCLES`.

## Operation
- Per key there are three parts: a 2-flop synchroniser, a 4-state FSM, and two counters. The debounce counter is `$clog2(DEBOUNCE_CYCLES)` bits wide and the long counter is `$clog2(LONG_CYCLES+1)` bits wide. Keys are fully independent.
- Reset (`RESETN` = 0), taking effect immediately:
  - synchroniser flops go to 1 (released);
  - FSM goes to IDLE and both counters go to 0;
  - all outputs go to 0.
- Let `s` = the synchroniser output, inverted, so that 1 means a pressed sample.
- IDLE (`KEY_LEVEL` = 0):
  - `s` = 1: go to PRESS_WAIT with the debounce counter at 1.
- PRESS_WAIT (`KEY_LEVEL` = 0):
  - `s` = 0: go to IDLE and clear the debounce counter. No pulse is produced.
  - `s` = 1 and the counter is below `DEBOUNCE_CYCLES-1`: increment the counter.
  - `s` = 1 and the counter equals `DEBOUNCE_CYCLES-1`: go to HELD, clear the long counter, and register `KEY_PRESS` = 1 and `KEY_LEVEL` = 1.
- HELD (`KEY_LEVEL` = 1):
  - The long counter increments each cycle while it is below `LONG_CYCLES`.
  - On the edge where it reaches `LONG_CYCLES`, register `KEY_LONG` = 1. This happens once per press; the counter then saturates.
  - `s` = 0: go to RELEASE_WAIT with the debounce counter at 1.
- RELEASE_WAIT (`KEY_LEVEL` = 1, long counter frozen):
  - `s` = 1: return to HELD and clear the debounce counter. The long counter resumes from its frozen value.
  - `s` = 0 and the counter is below `DEBOUNCE_CYCLES-1`: increment the counter.
  - `s` = 0 and the counter equals `DEBOUNCE_CYCLES-1`: go to IDLE and register `KEY_RELEASE` = 1 and `KEY_LEVEL` = 0.
- All pulse outputs are registered and are high for exactly one cycle. At most one pulse type fires per key per cycle. `KEY_LONG` can only occur strictly between that key's `KEY_PRESS` and `KEY_RELEASE`.
- Reset while a key is held:
  - no pulses are produced during reset;
  - after `RESETN` rises, a still-held key is accepted as a new press, with full latency counted from the first edge after reset release.

## Timing
- Let E0 be the first rising edge that captures `KEY[i]` = 0 into sync flop 1.
- Press latency: `s` is first seen pressed at E2. `KEY_PRESS[i]` and `KEY_LEVEL[i]` are visible after edge E(DEBOUNCE_CYCLES+1), provided `KEY[i]` stays low through E(DEBOUNCE_CYCLES-1).
- Release latency is symmetric: `KEY_RELEASE[i]` and `KEY_LEVEL[i]` = 0 are visible after edge E(DEBOUNCE_CYCLES+1), with E0 being the first edge capturing `KEY[i]` = 1.
- Long press: `KEY_LONG[i]` is visible `LONG_CYCLES` edges after the edge that raised `KEY_PRESS[i]`, if no cycles are spent in RELEASE_WAIT. Each cycle spent in RELEASE_WAIT delays it by one.
- Bounce rejection: any `s` disagreement during a WAIT state restarts acceptance from scratch. The next agreeing sample restarts the count at 1.
- There is no combinational path from `KEY` to any output.

## Test plan
All tests use `DEBOUNCE_CYCLES` = 4, `LONG_CYCLES` = 10, `NKEYS` = 2.
- Reset:
  - Stimulus: assert `RESETN` = 0 mid-cycle with `KEY` = 2'b00 held.
  - Required: all outputs are 0 immediately.
  - Stimulus: release reset with the keys still held.
  - Required: `KEY_PRESS` = 2'b11 for one cycle, 5 edges after the first post-reset edge.
- Clean press, hold and release:
  - Stimulus: `KEY[0]` goes low before E0 and is held 30 cycles, then goes high.
  - Required: `KEY_PRESS[0]` pulses after E5; `KEY_LONG[0]` pulses after E15.
  - Required: `KEY_RELEASE[0]` pulses 5 edges after the rise is first captured; `KEY_LEVEL[0]` tracks accordingly.
- Bounce on press:
  - Stimulus: `KEY[0]` = 0, 0, 1, 0, 0, 0, 0 sampled on consecutive edges.
  - Required: no pulse until 4 consecutive pressed samples, then exactly one `KEY_PRESS[0]`. `KEY_LEVEL[0]` never glitches.
- Short glitch:
  - Stimulus: `KEY[1]` low for 3 edges, then high.
  - Required: no `KEY_PRESS[1]` and `KEY_LEVEL[1]` stays 0.
  - Stimulus: in HELD, `KEY[1]` high for 3 edges.
  - Required: no `KEY_RELEASE[1]`, and `KEY_LONG` fires 3 cycles late.
- Independence:
  - Stimulus: press key 0 and key 1 two cycles apart.
  - Required: `KEY_PRESS` pulses occur 2 cycles apart with no cross-coupling.
  - Required: a short tap (< 10 held cycles) yields no `KEY_LONG`.
